// File: rtl/ldque_stld_violation_chk.sv
// Load-queue side store->load ordering checker: compares each store address broadcast
// against executed in-flight loads and reports the oldest load that read overlapping bytes too early.
module ldque_stld_violation_chk #(
  parameter int LQ_SIZE = 16,
  parameter int SQ_SIZE = 16,
  parameter int XLEN    = 64,
  localparam int LQW    = 1 + $clog2(LQ_SIZE),
  localparam int SQW    = 1 + $clog2(SQ_SIZE),
  localparam int VW     = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_alloc_vld,
  input  logic [LQW-1:0]  i_alloc_lqIdx,
  input  logic [SQW-1:0]  i_alloc_sqIdx,
  input  logic            i_ldwb_vld,
  input  logic [LQW-1:0]  i_ldwb_lqIdx,
  input  logic [XLEN-1:0] i_ldwb_vaddr,
  input  logic [VW-1:0]   i_ldwb_load_vec,
  input  logic            i_commit_vld,
  input  logic [LQW-1:0]  i_commit_lqIdx,
  input  logic            i_sta_s0_vld,
  input  logic [SQW-1:0]  i_sta_s0_sqIdx,
  input  logic [XLEN-1:0] i_sta_s0_vaddr,
  input  logic [VW-1:0]   i_sta_s0_store_vec,
  output logic            o_violation_vld,
  output logic [LQW-1:0]  o_violation_lqIdx
);

  localparam int LIW = LQW - 1;
  localparam int SIW = SQW - 1;
  localparam int AW  = XLEN - 3;

  // Interfaces are valid-only: every *_vld input is consumed in the cycle it is high
  // and the violation output is a single-cycle pulse; nothing here can stall.

  logic [LQ_SIZE-1:0] valid_q, valid_d;
  logic [LQ_SIZE-1:0] exec_q, exec_d;
  logic [LQW-1:0]     head_q, head_d;
  logic [SQW-1:0]     sqidx_q [LQ_SIZE];
  logic [AW-1:0]      addr_q  [LQ_SIZE];
  logic [VW-1:0]      vec_q   [LQ_SIZE];

  logic               s1_vld_q, s1_vld_d;
  logic [SQW-1:0]     s1_sqidx_q;
  logic [AW-1:0]      s1_addr_q;
  logic [VW-1:0]      s1_vec_q;

  logic [LQ_SIZE-1:0] hit_d;
  logic [LQ_SIZE-1:0] s2_hit_q, s2_hit_d;
  logic [LQ_SIZE-1:0] s2_live;
  logic               pick_found;
  logic [LIW-1:0]     pick_idx;
  logic [LIW-1:0]     pick_cand;
  logic               pick_flip;

  logic [LIW-1:0] a_idx, w_idx, c_idx;
  assign a_idx = i_alloc_lqIdx[LIW-1:0];
  assign w_idx = i_ldwb_lqIdx[LIW-1:0];
  assign c_idx = i_commit_lqIdx[LIW-1:0];

  logic unused_bits;
  assign unused_bits = ^{i_alloc_lqIdx[LIW], i_ldwb_lqIdx[LIW],
                         i_ldwb_vaddr[2:0], i_sta_s0_vaddr[2:0]};

  // Store S is older than load tail-stamp L when it precedes L in the wrapped SQ order.
  function automatic logic sta_older(input logic [SQW-1:0] s, input logic [SQW-1:0] l);
    if (s[SIW] == l[SIW]) return s[SIW-1:0] < l[SIW-1:0];
    else                  return s[SIW-1:0] >= l[SIW-1:0];
  endfunction

  always_comb begin
    valid_d = valid_q;
    exec_d  = exec_q;
    head_d  = head_q;
    if (i_flush) begin
      valid_d = '0;
      exec_d  = '0;
    end else begin
      if (i_commit_vld) begin
        valid_d[c_idx] = 1'b0;
        exec_d[c_idx]  = 1'b0;
        head_d         = i_commit_lqIdx + LQW'(1);
      end
      if (i_alloc_vld) begin
        valid_d[a_idx] = 1'b1;
        exec_d[a_idx]  = 1'b0;
      end
      if (i_ldwb_vld) exec_d[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      exec_q  <= '0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      exec_q  <= exec_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_flush) begin
      if (i_alloc_vld) sqidx_q[a_idx] <= i_alloc_sqIdx;
      if (i_ldwb_vld) begin
        addr_q[w_idx] <= i_ldwb_vaddr[XLEN-1:3];
        vec_q[w_idx]  <= i_ldwb_load_vec;
      end
    end
  end

  // S0: capture the broadcast
  assign s1_vld_d = i_sta_s0_vld & ~i_flush;

  always_ff @(posedge clk) begin
    if (!rst) s1_vld_q <= 1'b0;
    else      s1_vld_q <= s1_vld_d;
  end

  always_ff @(posedge clk) begin
    s1_sqidx_q <= i_sta_s0_sqIdx;
    s1_addr_q  <= i_sta_s0_vaddr[XLEN-1:3];
    s1_vec_q   <= i_sta_s0_store_vec;
  end

  // S1: per-entry overlap check against registered entry state
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < LQ_SIZE; i++) begin
      hit_d[i] = s1_vld_q & valid_q[i] & exec_q[i] &
                 (addr_q[i] == s1_addr_q) &
                 (|(vec_q[i] & s1_vec_q)) &
                 sta_older(s1_sqidx_q, sqidx_q[i]);
    end
  end

  assign s2_hit_d = i_flush ? '0 : hit_d;

  always_ff @(posedge clk) begin
    if (!rst) s2_hit_q <= '0;
    else      s2_hit_q <= s2_hit_d;
  end

  // S2: drop entries retired since S1, then choose the first hit walking from head
  assign s2_live = s2_hit_q & valid_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cand  = '0;
    for (int k = 0; k < LQ_SIZE; k++) begin
      pick_cand = head_q[LIW-1:0] + LIW'(k);
      if (!pick_found && s2_live[pick_cand]) begin
        pick_found = 1'b1;
        pick_idx   = pick_cand;
      end
    end
  end

  assign pick_flip         = (pick_idx >= head_q[LIW-1:0]) ? head_q[LIW] : ~head_q[LIW];
  assign o_violation_vld   = |s2_live;
  assign o_violation_lqIdx = pick_found ? {pick_flip, pick_idx} : '0;

endmodule
